// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Brief    : Configurable UART transmitter (5..9 data bits, none/even/odd
//            parity, 1/2 stop bits) with a one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_ready
);

    localparam int                    c_TICK_W    = $clog2(OVERSAMPLE);
    localparam int                    c_IDX_W     = $clog2(DATA_BITS);
    localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
    localparam logic                  c_STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_stop_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_hold;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_bit_end;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic                  w_parity;

    assign w_accept   = start & o_ready;
    assign w_bit_end  = baud_tick && (r_tick == c_TICK_LAST) && (r_state != S_IDLE);
    assign w_idx_next = r_idx + c_IDX_W'(1);
    assign w_parity   = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_hold     <= '0;
            r_valid    <= 1'b0;
            o_tx       <= 1'b1;
            o_tx_busy  <= 1'b0;
            o_tx_done  <= 1'b0;
            o_ready    <= 1'b1;
        end else begin
            o_tx_done <= 1'b0;

            if (w_accept) begin
                r_hold    <= din;
                r_valid   <= 1'b1;
                o_ready   <= 1'b0;
                o_tx_busy <= 1'b1;
            end

            if (r_state != S_IDLE && baud_tick) begin
                r_tick <= w_bit_end ? '0 : r_tick + c_TICK_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (r_valid) begin
                        r_shift <= r_hold;
                        r_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_idx   <= '0;
                        o_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == c_IDX_LAST) begin
                            if (PARITY != 0) begin
                                o_tx    <= w_parity;
                                r_state <= S_PAR;
                            end else begin
                                o_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_idx <= w_idx_next;
                            o_tx  <= r_shift[w_idx_next];
                        end
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        o_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == c_STOP_LAST) begin
                            o_tx_done <= 1'b1;
                            if (r_valid) begin
                                r_shift <= r_hold;
                                r_valid <= 1'b0;
                                o_ready <= 1'b1;
                                o_tx    <= 1'b0;
                                r_state <= S_START;
                            end else if (w_accept) begin
                                // Accept on the final tick launches straight from din,
                                // overriding the holding-register capture above.
                                r_shift <= din;
                                r_valid <= 1'b0;
                                o_ready <= 1'b1;
                                o_tx    <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                o_tx_busy <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_tx_cfg: four configurations (8N1 with a tick-level reference
// model, 8E1, 8O1, 7N2) driven by a shared clock and baud tick.
module tb_uart_tx_cfg;

    localparam int OS = 8;
    localparam int NB = 10;     // 8N1 frame length in bits

    logic        clk;
    logic        rst_n;
    logic        baud_tick;
    logic [3:0]  start_v;
    logic [8:0]  din_v [4];
    logic        tx0, tx1, tx2, tx3;
    logic        bz0, bz1, bz2, bz3;
    logic        dn0, dn1, dn2, dn3;
    logic        rd0, rd1, rd2, rd3;
    logic [3:0]  tx_v, busy_v, done_v, ready_v;

    assign tx_v    = {tx3, tx2, tx1, tx0};
    assign busy_v  = {bz3, bz2, bz1, bz0};
    assign done_v  = {dn3, dn2, dn1, dn0};
    assign ready_v = {rd3, rd2, rd1, rd0};

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst_n), .baud_tick(baud_tick), .start(start_v[0]), .din(din_v[0][7:0]),
        .o_tx(tx0), .o_tx_busy(bz0), .o_tx_done(dn0), .o_ready(rd0));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst_n), .baud_tick(baud_tick), .start(start_v[1]), .din(din_v[1][7:0]),
        .o_tx(tx1), .o_tx_busy(bz1), .o_tx_done(dn1), .o_ready(rd1));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst_n), .baud_tick(baud_tick), .start(start_v[2]), .din(din_v[2][7:0]),
        .o_tx(tx2), .o_tx_busy(bz2), .o_tx_done(dn2), .o_ready(rd2));
    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst_n), .baud_tick(baud_tick), .start(start_v[3]), .din(din_v[3][6:0]),
        .o_tx(tx3), .o_tx_busy(bz3), .o_tx_done(dn3), .o_ready(rd3));

    int checks = 0;
    int errors = 0;
    int done_cnt0 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every third clock, updated just after the rising edge.
    initial begin
        int tcnt;
        tcnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tcnt = (tcnt + 1) % 3;
            baud_tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
    endtask

    // ---------------- reference model for the 8N1 instance ----------------
    // The line is a pure function of ticks elapsed since launch.
    logic        m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_ready = 1'b1, m_active = 1'b0;
    int          m_ticks = 0;
    logic [7:0]  m_hold = 8'h00;
    logic [15:0] m_frame = 16'h0;

    function automatic logic [15:0] frame_8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    initial begin
        logic acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;
                m_active = 1'b0; m_ticks = 0;
            end else begin
                acc    = start_v[0] && m_ready;
                m_done = 1'b0;
                if (m_active) begin
                    if (baud_tick) begin
                        m_ticks++;
                        if (m_ticks == NB * OS) begin
                            m_done = 1'b1;
                            if (!m_ready) begin
                                m_frame = frame_8n1(m_hold); m_ticks = 0; m_ready = 1'b1;
                            end else if (acc) begin
                                m_frame = frame_8n1(din_v[0][7:0]); m_ticks = 0; acc = 1'b0;
                            end else begin
                                m_active = 1'b0; m_busy = 1'b0;
                            end
                        end
                    end
                end else if (!m_ready) begin
                    m_frame = frame_8n1(m_hold); m_ticks = 0;
                    m_active = 1'b1; m_ready = 1'b1; m_busy = 1'b1;
                end
                if (acc) begin
                    m_hold = din_v[0][7:0]; m_ready = 1'b0; m_busy = 1'b1;
                end
                m_tx = m_active ? m_frame[m_ticks / OS] : 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_tx",    {31'b0, tx0}, {31'b0, m_tx});
            check("model_busy",  {31'b0, bz0}, {31'b0, m_busy});
            check("model_done",  {31'b0, dn0}, {31'b0, m_done});
            check("model_ready", {31'b0, rd0}, {31'b0, m_ready});
            if (dn0) done_cnt0++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input int k, input logic [8:0] d);
        @(posedge clk); #2;
        start_v[k] = 1'b1;
        din_v[k]   = d;
        @(posedge clk); #2;
        start_v[k] = 1'b0;
        din_v[k]   = ~d;
    endtask

    // which: 0 = tx, 1 = ready, 2 = done
    task automatic wait_for(input int k, input int which, input logic val, input string name);
        logic s;
        bit   hit;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       s = tx_v[k];
                1:       s = ready_v[k];
                default: s = done_v[k];
            endcase
            if (s == val) hit = 1;
        end
        if (!hit) timeout(name);
    endtask

    // Samples each bit mid-period, counts ticks from launch until o_tx_done.
    task automatic capture(input int k, input bit now, output logic [15:0] bits, output int n);
        bit started, fin;
        started = 0; fin = 0; n = 0; bits = '0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (!(now && i == 0)) @(negedge clk);
            if (!started && tx_v[k] == 1'b0) started = 1;
            if (started) begin
                if (done_v[k] && n > 0) fin = 1;
                else if (baud_tick) begin
                    if (n % OS == OS / 2 && n / OS < 16) bits[n / OS] = tx_v[k];
                    n++;
                end
            end
        end
        if (!fin) timeout("capture");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] bits;
        int          n, base;
        bit          hit;

        rst_n   = 1'b0;
        start_v = 4'b0;
        for (int k = 0; k < 4; k++) din_v[k] = 9'h0;
        repeat (3) @(negedge clk);
        check("reset_tx",    {28'b0, tx_v},    32'hF);
        check("reset_busy",  {28'b0, busy_v},  32'h0);
        check("reset_done",  {28'b0, done_v},  32'h0);
        check("reset_ready", {28'b0, ready_v}, 32'hF);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 8N1 0xA5 with launch latency
        pulse(0, 9'h0A5);
        @(negedge clk);
        check("lat_ready_low", {31'b0, rd0}, 32'h0);
        check("lat_busy_early", {31'b0, bz0}, 32'h1);
        check("lat_tx_idle", {31'b0, tx0}, 32'h1);
        @(negedge clk);
        check("lat_tx_start", {31'b0, tx0}, 32'h0);
        check("lat_ready_back", {31'b0, rd0}, 32'h1);
        capture(0, 1, bits, n);
        check("8n1_frame", {22'b0, bits[9:0]}, 32'h34A);
        check("8n1_ticks", n, 80);
        check("8n1_busy_fall", {31'b0, bz0}, 32'h0);
        @(negedge clk);
        check("8n1_done_1cyc", {31'b0, dn0}, 32'h0);

        // 8E1 / 8O1 / 7N2 (din changes after accept inside pulse)
        pulse(1, 9'h007);
        capture(1, 0, bits, n);
        check("8e1_frame", {21'b0, bits[10:0]}, 32'h60E);
        check("8e1_ticks", n, 88);
        pulse(2, 9'h007);
        capture(2, 0, bits, n);
        check("8o1_frame", {21'b0, bits[10:0]}, 32'h40E);
        check("8o1_ticks", n, 88);
        pulse(3, 9'h07F);
        capture(3, 0, bits, n);
        check("7n2_frame", {22'b0, bits[9:0]}, 32'h3FE);
        check("7n2_ticks", n, 80);
        check("7n2_busy_fall", {31'b0, bz3}, 32'h0);

        // Back-to-back with a rejected third request
        base = done_cnt0;
        pulse(0, 9'h055);
        wait_for(0, 1, 1'b1, "b2b_launch");
        pulse(0, 9'h00F);
        @(negedge clk);
        check("b2b_ready_drop", {31'b0, rd0}, 32'h0);
        pulse(0, 9'h0FF);
        wait_for(0, 2, 1'b1, "b2b_first_done");
        check("b2b_no_gap_tx", {31'b0, tx0}, 32'h0);
        check("b2b_busy_held", {31'b0, bz0}, 32'h1);
        capture(0, 1, bits, n);
        check("b2b_frame2", {22'b0, bits[9:0]}, 32'h21E);
        check("b2b_ticks2", n, 80);
        check("b2b_busy_fall", {31'b0, bz0}, 32'h0);
        repeat (300) @(negedge clk);
        check("b2b_done_count", done_cnt0 - base, 2);

        // Reset during data bit 3
        pulse(0, 9'h096);
        wait_for(0, 0, 1'b0, "rst_launch");
        n = 0;
        for (int i = 0; i < 500 && n < 36; i++) begin
            if (i > 0) @(negedge clk);
            if (baud_tick) n++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx",    {31'b0, tx0}, 32'h1);
        check("rst_mid_busy",  {31'b0, bz0}, 32'h0);
        check("rst_mid_ready", {31'b0, rd0}, 32'h1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        pulse(0, 9'h03C);
        capture(0, 0, bits, n);
        check("rst_after_frame", {22'b0, bits[9:0]}, 32'h278);
        check("rst_after_ticks", n, 80);

        // Accept coincident with the final stop tick
        pulse(0, 9'h05A);
        wait_for(0, 0, 1'b0, "coinc_launch");
        n = 0; hit = 0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (i > 0) @(negedge clk);
            if (baud_tick) begin
                if (n == 79) begin
                    start_v[0] = 1'b1;
                    din_v[0]   = 9'h0C3;
                    hit = 1;
                end else n++;
            end
        end
        if (!hit) timeout("coinc_final_tick");
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        din_v[0]   = 9'h000;
        @(negedge clk);
        check("coinc_done", {31'b0, dn0}, 32'h1);
        check("coinc_no_gap", {31'b0, tx0}, 32'h0);
        check("coinc_busy", {31'b0, bz0}, 32'h1);
        capture(0, 1, bits, n);
        check("coinc_frame", {22'b0, bits[9:0]}, 32'h386);
        check("coinc_ticks", n, 80);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
